// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
// Contents:
//   mem_sel_t    MemoryManager select encoding (weights / intermediate / I/O / illegal)
//   arb_state_t  arbiter mode: free round-robin or locked onto one requester
//   LOCK_TIMEOUT idle cycles of the lock owner before the lock is forcibly dropped
package mem_arb_pkg;

  typedef enum logic [1:0] {
    SEL_WEIGHTS = 2'b00,
    SEL_INTER   = 2'b01,
    SEL_IO      = 2'b10,
    SEL_ILLEGAL = 2'b11
  } mem_sel_t;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int LOCK_TIMEOUT = 16;
  localparam int LOCK_CNT_W   = $clog2(LOCK_TIMEOUT);

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector
// Ports:
//   req    in  N   request vector
//   ptr    in  IW  index of the last winner; search starts at ptr+1 and wraps
//   grant  out N   one-hot grant (all zero when no request)
//   idx    out IW  index of the granted requester
//   any    out 1   at least one request present
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    // i runs 1..N so the last winner is examined last.
    for (int i = 1; i <= N; i++) begin
      if (!any && req[(int'(ptr) + i) % N]) begin
        any                          = 1'b1;
        grant[(int'(ptr) + i) % N]   = 1'b1;
        idx                          = IW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing the single MemoryManager port
// Optional feature macro: MEM_ARB_LOCK_EN (adds req_lock and the LOCKED mode with watchdog).
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req_valid/req_we   per-requester valid and write flag
//   req_sel/addr/wdata per-requester packed select (2b), address (AW), write data (DW)
//   req_lock           per-requester lock request (MEM_ARB_LOCK_EN only)
//   req_ready          one-hot grant, combinational; beat accepted on valid&&ready
//   rsp_valid/rsp_data one-hot read response and shared read data
//   mem_*              registered MemoryManager inputs, mem_data_out its read data
//   err_sel            sticky illegal-select / lock-watchdog error
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ-1:0]    req_we,
  input  logic [2*N_REQ-1:0]  req_sel,
  input  logic [AW*N_REQ-1:0] req_addr,
  input  logic [DW*N_REQ-1:0] req_wdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic [N_REQ-1:0]    req_lock,
`endif
  output logic [N_REQ-1:0]    req_ready,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]       rsp_data,
  output logic [DW-1:0]       mem_data_in,
  output logic [AW-1:0]       mem_address,
  output logic                mem_write_enable,
  output logic [1:0]          mem_select,
  input  logic [DW-1:0]       mem_data_out,
  output logic                err_sel
);

  localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // One stage for the mem_* register plus RD_LAT for the memory itself.
  localparam int DEPTH = 1 + RD_LAT;

  logic [IW-1:0]    rr_ptr;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    win_idx;
  logic             accept;
  mem_sel_t         win_sel;
  logic             win_we;
  logic             win_ill;
  logic [AW-1:0]    win_addr;
  logic [DW-1:0]    win_wdata;
  logic             wd_fire;

  logic [DEPTH-1:0]         pipe_vld;
  logic [DEPTH-1:0]         pipe_ill;
  logic [DEPTH-1:0][IW-1:0] pipe_idx;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req   (eligible),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win_idx),
    .any   (accept)
  );

  // Ready only goes to valid requesters, so any grant is an accepted beat.
  assign req_ready = grant;
  assign win_sel   = mem_sel_t'(req_sel[2*win_idx +: 2]);
  assign win_we    = req_we[win_idx];
  assign win_addr  = req_addr[AW*win_idx +: AW];
  assign win_wdata = req_wdata[DW*win_idx +: DW];
  assign win_ill   = (win_sel == SEL_ILLEGAL);

`ifdef MEM_ARB_LOCK_EN
  arb_state_t            state;
  logic [IW-1:0]         lock_owner;
  logic [LOCK_CNT_W-1:0] wd_cnt;
  logic [N_REQ-1:0]      owner_mask;

  assign owner_mask = N_REQ'(1) << lock_owner;
  assign eligible   = ((state == LOCKED) ? (req_valid & owner_mask) : req_valid) & {N_REQ{rst_n}};
  // Fires on the LOCK_TIMEOUT-th consecutive idle cycle of the owner.
  assign wd_fire    = (state == LOCKED) && !req_valid[lock_owner] &&
                      (wd_cnt == LOCK_CNT_W'(LOCK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB;
      lock_owner <= '0;
      wd_cnt     <= '0;
    end else begin
      case (state)
        ARB: begin
          if (accept && req_lock[win_idx]) begin
            state      <= LOCKED;
            lock_owner <= win_idx;
            wd_cnt     <= '0;
          end
        end
        LOCKED: begin
          if (accept) begin
            wd_cnt <= '0;
            if (!req_lock[win_idx]) state <= ARB;
          end else if (!req_valid[lock_owner]) begin
            if (wd_fire) begin
              state  <= ARB;
              wd_cnt <= '0;
            end else begin
              wd_cnt <= wd_cnt + 1'b1;
            end
          end else begin
            wd_cnt <= '0;
          end
        end
        default: state <= ARB;
      endcase
    end
  end
`else
  // Ready is held low while reset is asserted.
  assign eligible = req_valid & {N_REQ{rst_n}};
  assign wd_fire  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr           <= IW'(N_REQ - 1);
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_data_in      <= '0;
      mem_select       <= SEL_WEIGHTS;
      err_sel          <= 1'b0;
      pipe_vld         <= '0;
      pipe_ill         <= '0;
      pipe_idx         <= '0;
    end else begin
      mem_write_enable <= accept && win_we && !win_ill;
      if (accept) begin
        rr_ptr <= win_idx;
        // Illegal selects never reach the memory: address/select/data hold.
        if (!win_ill) begin
          mem_address <= win_addr;
          mem_data_in <= win_wdata;
          mem_select  <= win_sel;
        end
      end
      if ((accept && win_ill) || wd_fire) err_sel <= 1'b1;
      // Writes and idle cycles push an empty slot.
      pipe_vld <= {pipe_vld[DEPTH-2:0], accept && !win_we};
      pipe_ill <= {pipe_ill[DEPTH-2:0], accept && win_ill};
      pipe_idx <= {pipe_idx[DEPTH-2:0], win_idx};
    end
  end

  // Memory data lands in the same cycle the tag leaves the pipeline.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (pipe_vld[DEPTH-1]) begin
      rsp_valid[pipe_idx[DEPTH-1]] = 1'b1;
      rsp_data = pipe_ill[DEPTH-1] ? '0 : mem_data_out;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid, req_we, req_ready, rsp_valid;
  logic [5:0]  req_sel;
  logic [47:0] req_addr, req_wdata;
  logic [15:0] rsp_data, mem_data_in, mem_address, mem_data_out;
  logic        mem_write_enable, err_sel;
  logic [1:0]  mem_select;
`ifdef MEM_ARB_LOCK_EN
  logic [2:0]  req_lock;
`endif

  int applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.N_REQ(3), .AW(16), .DW(16), .RD_LAT(1)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_we           (req_we),
    .req_sel          (req_sel),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
`ifdef MEM_ARB_LOCK_EN
    .req_lock         (req_lock),
`endif
    .req_ready        (req_ready),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data),
    .mem_data_in      (mem_data_in),
    .mem_address      (mem_address),
    .mem_write_enable (mem_write_enable),
    .mem_select       (mem_select),
    .mem_data_out     (mem_data_out),
    .err_sel          (err_sel)
  );

  // MemoryManager model, one-cycle read latency; preloaded with A000|sel<<8|addr.
  logic [15:0] tb_mem [4][16];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < 4; s++)
        for (int a = 0; a < 16; a++)
          tb_mem[s][a] <= 16'hA000 | 16'(s << 8) | 16'(a);
    end else if (mem_write_enable) begin
      tb_mem[mem_select][mem_address[3:0]] <= mem_data_in;
    end
    mem_data_out <= tb_mem[mem_select][mem_address[3:0]];
  end

  typedef struct {
    logic [2:0]  valid, we;
    logic [5:0]  sel;
    logic [47:0] addr, wdata;
    logic [2:0]  x_ready;
    logic        x_we;
    logic [15:0] x_addr;
    logic [1:0]  x_sel;
    logic [15:0] x_wdata;
    logic [2:0]  x_rsp;
    logic [15:0] x_rdata;
    logic        x_err;
  } vec_t;

  function automatic vec_t mk(logic [2:0] valid, logic [2:0] we, logic [5:0] sel,
                              logic [47:0] addr, logic [47:0] wdata, logic [2:0] x_ready,
                              logic x_we, logic [15:0] x_addr, logic [1:0] x_sel,
                              logic [15:0] x_wdata, logic [2:0] x_rsp, logic [15:0] x_rdata,
                              logic x_err);
    vec_t v;
    v.valid = valid; v.we = we; v.sel = sel; v.addr = addr; v.wdata = wdata;
    v.x_ready = x_ready; v.x_we = x_we; v.x_addr = x_addr; v.x_sel = x_sel;
    v.x_wdata = x_wdata; v.x_rsp = x_rsp; v.x_rdata = x_rdata; v.x_err = x_err;
    return v;
  endfunction

  task automatic drive(input logic [2:0] valid, input logic [2:0] we, input logic [5:0] sel,
                       input logic [47:0] addr, input logic [47:0] wdata);
    req_valid = valid; req_we = we; req_sel = sel; req_addr = addr; req_wdata = wdata;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

`ifdef MEM_ARB_LOCK_EN
  task automatic cyc(input string name, input logic [2:0] valid, input logic [2:0] lock,
                     input logic [2:0] x_ready);
    @(posedge clk); #1;
    drive(valid, 3'b111, 6'b0, 48'h0, 48'h0);
    req_lock = lock;
    @(negedge clk);
    chk(name, {29'b0, req_ready}, {29'b0, x_ready});
  endtask
`endif

  localparam logic [5:0]  R_SEL  = 6'b10_01_00;
  localparam logic [47:0] R_ADDR = 48'h0007_0003_0002;

  vec_t vt[24];

  initial begin
    vt[0]  = mk(3'b000, 3'b000, 6'b0, 48'h0, 48'h0, 3'b000, 0, 16'h0, 2'b00, 16'h0, 3'b000, 16'h0, 0);
    // single requester write then read back
    vt[1]  = mk(3'b001, 3'b001, 6'b0, 48'h0, 48'h1234, 3'b001, 0, 16'h0, 2'b00, 16'h0, 3'b000, 16'h0, 0);
    vt[2]  = mk(3'b001, 3'b000, 6'b0, 48'h0, 48'h0, 3'b001, 1, 16'h0, 2'b00, 16'h1234, 3'b000, 16'h0, 0);
    vt[3]  = mk(3'b000, 3'b000, 6'b0, 48'h0, 48'h0, 3'b000, 0, 16'h0, 2'b00, 16'h0, 3'b000, 16'h0, 0);
    vt[4]  = mk(3'b000, 3'b000, 6'b0, 48'h0, 48'h0, 3'b000, 0, 16'h0, 2'b00, 16'h0, 3'b001, 16'h1234, 0);
    // req1 write then req2 read of the same location
    vt[5]  = mk(3'b110, 3'b010, 6'b01_01_00, 48'h0005_0005_0000, 48'h0000_5678_0000,
                3'b010, 0, 16'h0, 2'b00, 16'h0, 3'b000, 16'h0, 0);
    vt[6]  = mk(3'b100, 3'b000, 6'b01_00_00, 48'h0005_0000_0000, 48'h0,
                3'b100, 1, 16'h5, 2'b01, 16'h5678, 3'b000, 16'h0, 0);
    vt[7]  = mk(3'b000, 3'b000, 6'b0, 48'h0, 48'h0, 3'b000, 0, 16'h5, 2'b01, 16'h0, 3'b000, 16'h0, 0);
    vt[8]  = mk(3'b000, 3'b000, 6'b0, 48'h0, 48'h0, 3'b000, 0, 16'h5, 2'b01, 16'h0, 3'b100, 16'h5678, 0);
    // three continuous readers: rotation and response routing
    vt[9]  = mk(3'b111, 3'b000, R_SEL, R_ADDR, 48'h0, 3'b001, 0, 16'h5, 2'b01, 16'h0, 3'b000, 16'h0, 0);
    vt[10] = mk(3'b111, 3'b000, R_SEL, R_ADDR, 48'h0, 3'b010, 0, 16'h2, 2'b00, 16'h0, 3'b000, 16'h0, 0);
    vt[11] = mk(3'b111, 3'b000, R_SEL, R_ADDR, 48'h0, 3'b100, 0, 16'h3, 2'b01, 16'h0, 3'b001, 16'hA002, 0);
    vt[12] = mk(3'b111, 3'b000, R_SEL, R_ADDR, 48'h0, 3'b001, 0, 16'h7, 2'b10, 16'h0, 3'b010, 16'hA103, 0);
    vt[13] = mk(3'b111, 3'b000, R_SEL, R_ADDR, 48'h0, 3'b010, 0, 16'h2, 2'b00, 16'h0, 3'b100, 16'hA207, 0);
    vt[14] = mk(3'b111, 3'b000, R_SEL, R_ADDR, 48'h0, 3'b100, 0, 16'h3, 2'b01, 16'h0, 3'b001, 16'hA002, 0);
    vt[15] = mk(3'b000, 3'b000, 6'b0, 48'h0, 48'h0, 3'b000, 0, 16'h7, 2'b10, 16'h0, 3'b010, 16'hA103, 0);
    vt[16] = mk(3'b000, 3'b000, 6'b0, 48'h0, 48'h0, 3'b000, 0, 16'h7, 2'b10, 16'h0, 3'b100, 16'hA207, 0);
    vt[17] = mk(3'b000, 3'b000, 6'b0, 48'h0, 48'h0, 3'b000, 0, 16'h7, 2'b10, 16'h0, 3'b000, 16'h0, 0);
    // illegal-select read and write
    vt[18] = mk(3'b001, 3'b000, 6'b00_00_11, 48'h0000_0000_0009, 48'h0,
                3'b001, 0, 16'h7, 2'b10, 16'h0, 3'b000, 16'h0, 0);
    vt[19] = mk(3'b000, 3'b000, 6'b0, 48'h0, 48'h0, 3'b000, 0, 16'h7, 2'b10, 16'h0, 3'b000, 16'h0, 1);
    vt[20] = mk(3'b000, 3'b000, 6'b0, 48'h0, 48'h0, 3'b000, 0, 16'h7, 2'b10, 16'h0, 3'b001, 16'h0, 1);
    vt[21] = mk(3'b010, 3'b010, 6'b00_11_00, 48'h0000_0001_0000, 48'h0000_FFFF_0000,
                3'b010, 0, 16'h7, 2'b10, 16'h0, 3'b000, 16'h0, 1);
    vt[22] = mk(3'b000, 3'b000, 6'b0, 48'h0, 48'h0, 3'b000, 0, 16'h7, 2'b10, 16'h0, 3'b000, 16'h0, 1);
    vt[23] = mk(3'b000, 3'b000, 6'b0, 48'h0, 48'h0, 3'b000, 0, 16'h7, 2'b10, 16'h0, 3'b000, 16'h0, 1);

    rst_n = 1'b0;
    drive(3'b000, 3'b000, 6'b0, 48'h0, 48'h0);
`ifdef MEM_ARB_LOCK_EN
    req_lock = 3'b000;
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      drive(vt[i].valid, vt[i].we, vt[i].sel, vt[i].addr, vt[i].wdata);
      @(negedge clk);
      applied++;
      if (req_ready !== vt[i].x_ready || mem_write_enable !== vt[i].x_we ||
          mem_address !== vt[i].x_addr || mem_select !== vt[i].x_sel ||
          mem_data_in !== vt[i].x_wdata || rsp_valid !== vt[i].x_rsp ||
          rsp_data !== vt[i].x_rdata || err_sel !== vt[i].x_err) begin
        miscompares++;
        $display("FAIL vec%0d: got ready=%b we=%b addr=%h sel=%b wdata=%h rsp=%b rdata=%h err=%b; expected ready=%b we=%b addr=%h sel=%b wdata=%h rsp=%b rdata=%h err=%b",
                 i, req_ready, mem_write_enable, mem_address, mem_select, mem_data_in,
                 rsp_valid, rsp_data, err_sel, vt[i].x_ready, vt[i].x_we, vt[i].x_addr,
                 vt[i].x_sel, vt[i].x_wdata, vt[i].x_rsp, vt[i].x_rdata, vt[i].x_err);
      end
    end

    // reset with two reads in flight
    @(posedge clk); #1;
    drive(3'b001, 3'b000, 6'b0, 48'h0000_0000_0002, 48'h0);
    @(negedge clk);
    chk("rst_rd0_ready", {29'b0, req_ready}, 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_rd1_ready", {29'b0, req_ready}, 32'h1);
    @(posedge clk); #1;
    drive(3'b000, 3'b000, 6'b0, 48'h0, 48'h0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_outputs", {req_ready, rsp_valid, mem_write_enable, mem_select, err_sel},
        32'h0);
    chk("rst_mem_bus", {mem_address, mem_data_in}, 32'h0);
    chk("rst_rsp_data", {16'h0, rsp_data}, 32'h0);
    drive(3'b111, 3'b111, 6'b0, 48'h0, 48'h0);
    @(negedge clk);
    chk("rst_ready_held", {29'b0, req_ready}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_first_grant", {29'b0, req_ready}, 32'h1);
    @(posedge clk); #1;
    drive(3'b000, 3'b000, 6'b0, 48'h0, 48'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_no_rsp", {29'b0, rsp_valid}, 32'h0);
      @(posedge clk); #1;
    end

`ifdef MEM_ARB_LOCK_EN
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc("lock_b0", 3'b100, 3'b100, 3'b100);
    cyc("lock_b1", 3'b111, 3'b100, 3'b100);
    cyc("lock_b2", 3'b111, 3'b100, 3'b100);
    cyc("lock_b3", 3'b111, 3'b000, 3'b100);
    cyc("lock_rr0", 3'b011, 3'b000, 3'b001);
    cyc("lock_rr1", 3'b011, 3'b000, 3'b010);
    cyc("wd_lock", 3'b100, 3'b100, 3'b100);
    for (int k = 0; k < 16; k++) cyc("wd_stall", 3'b001, 3'b000, 3'b000);
    chk("wd_err_pre", {31'b0, err_sel}, 32'h0);
    cyc("wd_release", 3'b001, 3'b000, 3'b001);
    chk("wd_err_post", {31'b0, err_sel}, 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
